// File: rtl/soldier_btn_cmd.sv
// soldier_btn_cmd: turns the raw btn_L / btn_R board buttons into single-cycle
// push / pop strobes for the soldier queue. Each button goes through a
// two-flop synchronizer, a debouncer and a strobe FSM. A shared output stage
// keeps push and pop mutually exclusive.
//
// Build option:
//   SOLDIER_BTN_AUTO_REPEAT_EN  defined   -> IDLE/HELD/REPEAT FSM with auto-repeat
//                               undefined -> IDLE/HELD FSM, one strobe per press;
//                                            REPEAT_DELAY / REPEAT_PERIOD ignored
//
// Channel index 0 is the left button (push), index 1 is the right button (pop).
module soldier_btn_cmd #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 15_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_L,
   input  logic btn_R,
   output logic push,
   output logic pop,
   output logic lvl_L,
   output logic lvl_R
);

   // Parameter legality, checked at elaboration time.
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("soldier_btn_cmd: DEBOUNCE_CYCLES must be 1 or more");
   end
   if (REPEAT_DELAY < 2) begin : g_bad_delay
      $error("soldier_btn_cmd: REPEAT_DELAY must be 2 or more");
   end
   if (REPEAT_PERIOD < 2) begin : g_bad_period
      $error("soldier_btn_cmd: REPEAT_PERIOD must be 2 or more");
   end

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The counter holds values 0..DEBOUNCE_CYCLES-1; the cycle that would
   // make it reach DEBOUNCE_CYCLES toggles the level and clears it instead.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      raw;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      lvl;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      ev;
   logic            pend;

   assign raw   = {btn_R, btn_L};
   assign lvl_L = lvl[0];
   assign lvl_R = lvl[1];

   // Two-flop synchronizers for both asynchronous button inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debouncers: the level flips only after DEBOUNCE_CYCLES consecutive
   // cycles of disagreement; any agreeing cycle restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl       <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               lvl[i]    <= ~lvl[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

`ifdef SOLDIER_BTN_AUTO_REPEAT_EN

   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RC_W    = $clog2(RPT_MAX);
   localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      HELD,
      REPEAT
   } state_t;

   state_t          state     [2];
   state_t          state_nx  [2];
   logic [RC_W-1:0] rpt_cnt   [2];
   logic [RC_W-1:0] rpt_cnt_nx[2];

   // Strobe FSM state and repeat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state[0]   <= IDLE;
         state[1]   <= IDLE;
         rpt_cnt[0] <= '0;
         rpt_cnt[1] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            state[i]   <= state_nx[i];
            rpt_cnt[i] <= rpt_cnt_nx[i];
         end
      end
   end

   // Next-state logic: a debounced release wins over a repeat tick so a
   // release never produces a strobe.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         state_nx[i]   = state[i];
         rpt_cnt_nx[i] = rpt_cnt[i];
         case (state[i])
            IDLE: begin
               rpt_cnt_nx[i] = '0;
               if (lvl[i]) begin
                  state_nx[i] = HELD;
               end
            end
            HELD: begin
               if (!lvl[i]) begin
                  state_nx[i]   = IDLE;
                  rpt_cnt_nx[i] = '0;
               end else if (rpt_cnt[i] == DELAY_LAST) begin
                  state_nx[i]   = REPEAT;
                  rpt_cnt_nx[i] = '0;
               end else begin
                  rpt_cnt_nx[i] = rpt_cnt[i] + RC_W'(1);
               end
            end
            REPEAT: begin
               if (!lvl[i]) begin
                  state_nx[i]   = IDLE;
                  rpt_cnt_nx[i] = '0;
               end else if (rpt_cnt[i] == PERIOD_LAST) begin
                  rpt_cnt_nx[i] = '0;
               end else begin
                  rpt_cnt_nx[i] = rpt_cnt[i] + RC_W'(1);
               end
            end
            default: begin
               state_nx[i]   = IDLE;
               rpt_cnt_nx[i] = '0;
            end
         endcase
      end
   end

   // Event decode: press edge, first repeat and periodic repeats.
   always_comb begin
      ev = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         case (state[i])
            IDLE:    ev[i] = lvl[i];
            HELD:    ev[i] = lvl[i] && (rpt_cnt[i] == DELAY_LAST);
            REPEAT:  ev[i] = lvl[i] && (rpt_cnt[i] == PERIOD_LAST);
            default: ev[i] = 1'b0;
         endcase
      end
   end

`else

   typedef enum logic {
      IDLE,
      HELD
   } state_t;

   state_t state    [2];
   state_t state_nx [2];

   // Strobe FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state[0] <= IDLE;
         state[1] <= IDLE;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            state[i] <= state_nx[i];
         end
      end
   end

   // Next-state logic: HELD persists for as long as the debounced level is high.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         state_nx[i] = state[i];
         case (state[i])
            IDLE:    if (lvl[i])  state_nx[i] = HELD;
            HELD:    if (!lvl[i]) state_nx[i] = IDLE;
            default: state_nx[i] = IDLE;
         endcase
      end
   end

   // Event decode: only the debounced press edge produces an event.
   always_comb begin
      ev = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         ev[i] = (state[i] == IDLE) && lvl[i];
      end
   end

`endif

   // Output stage: push takes priority; a colliding pop is deferred by one
   // cycle through pend, which lasts exactly one cycle because right events
   // are at least two cycles apart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push <= 1'b0;
         pop  <= 1'b0;
         pend <= 1'b0;
      end else begin
         push <= ev[0];
         pop  <= (ev[1] & ~ev[0]) | pend;
         pend <= ev[1] & ev[0];
      end
   end

endmodule
